// File: rtl/uart_frame_ctrl_if.sv
// Byte-stream input, register-write output and frame status of the UART frame controller.
interface uart_frame_ctrl_if;
  logic [7:0] rxData;
  logic       rxValid;
  logic       regWrReady;
  logic       regWrEn;
  logic [7:0] regAddr;
  logic [7:0] regWrData;
  logic       frameDone;
  logic       frameErr;
  logic [1:0] errCode;
  logic       busy;

  // Frame controller side
  modport slave (
    input  rxData, rxValid, regWrReady,
    output regWrEn, regAddr, regWrData, frameDone, frameErr, errCode, busy
  );

  // Byte source / register file / status observer side
  modport master (
    output rxData, rxValid, regWrReady,
    input  regWrEn, regAddr, regWrData, frameDone, frameErr, errCode, busy
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Frame controller: hunts for SYNC, collects ADDR/LEN/payload/CHK into a buffer,
// and on a good checksum replays the payload as a register-write burst.
module uart_frame_ctrl #(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input logic              clk,
  input logic              resetn,
  uart_frame_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]       LEN_MAX  = 9'(MAX_LEN);

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TMO     = 2'd3;

  typedef enum logic [2:0] {
    S_HUNT, S_GET_ADDR, S_GET_LEN, S_GET_DATA, S_GET_CHK, S_COMMIT
  } state_t;

  state_t     r_state, w_state_nxt;

  logic [7:0] r_buf [MAX_LEN];
  logic [7:0] r_base;
  logic [7:0] r_len;
  logic [7:0] r_idx;
  logic [7:0] r_xor;
  logic [TMO_W-1:0] r_tmo;

  logic       r_wr_en,  w_wr_en_nxt;
  logic [7:0] r_addr,   w_addr_nxt;
  logic [7:0] r_data,   w_data_nxt;
  logic       r_done,   w_done_nxt;
  logic       r_err,    w_err_nxt;
  logic [1:0] r_code,   w_code_nxt;
  logic       r_busy,   w_busy_nxt;

  logic [7:0] w_rx_data;
  logic       w_rx_valid;
  logic       w_wr_ready;
  logic       w_in_frame;
  logic       w_tmo_exp;
  logic       w_len_bad;
  logic       w_chk_ok;
  logic       w_idx_last;
  logic       w_wr_fire;
  logic [7:0] w_idx_inc;

  assign w_rx_data  = bus.rxData;
  assign w_rx_valid = bus.rxValid;
  assign w_wr_ready = bus.regWrReady;

  assign bus.regWrEn   = r_wr_en;
  assign bus.regAddr   = r_addr;
  assign bus.regWrData = r_data;
  assign bus.frameDone = r_done;
  assign bus.frameErr  = r_err;
  assign bus.errCode   = r_code;
  assign bus.busy      = r_busy;

  // Decode terms shared by the next-state and output logic
  assign w_in_frame = (r_state == S_GET_ADDR) || (r_state == S_GET_LEN) ||
                      (r_state == S_GET_DATA) || (r_state == S_GET_CHK);
  assign w_tmo_exp  = w_in_frame && !w_rx_valid && (r_tmo == TMO_LAST);
  assign w_len_bad  = (w_rx_data == 8'h00) || ({1'b0, w_rx_data} > LEN_MAX);
  assign w_chk_ok   = ((r_xor ^ w_rx_data) == 8'h00);
  assign w_idx_last = (r_idx == (r_len - 8'd1));
  assign w_wr_fire  = r_wr_en && w_wr_ready;
  assign w_idx_inc  = r_idx + 8'd1;

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_HUNT;
      r_wr_en <= 1'b0;
      r_addr  <= 8'h00;
      r_data  <= 8'h00;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_wr_en_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_code  <= w_code_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state: a received byte always wins over timeout expiry in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_HUNT: begin
        if (w_rx_valid && (w_rx_data == SYNC_BYTE)) w_state_nxt = S_GET_ADDR;
      end
      S_GET_ADDR: begin
        if (w_rx_valid)     w_state_nxt = S_GET_LEN;
        else if (w_tmo_exp) w_state_nxt = S_HUNT;
      end
      S_GET_LEN: begin
        if (w_rx_valid)     w_state_nxt = w_len_bad ? S_HUNT : S_GET_DATA;
        else if (w_tmo_exp) w_state_nxt = S_HUNT;
      end
      S_GET_DATA: begin
        if (w_rx_valid && w_idx_last) w_state_nxt = S_GET_CHK;
        else if (w_tmo_exp)           w_state_nxt = S_HUNT;
      end
      S_GET_CHK: begin
        if (w_rx_valid)     w_state_nxt = w_chk_ok ? S_COMMIT : S_HUNT;
        else if (w_tmo_exp) w_state_nxt = S_HUNT;
      end
      S_COMMIT: begin
        if (w_wr_fire && w_idx_last) w_state_nxt = S_HUNT;
      end
      default: w_state_nxt = S_HUNT;
    endcase
  end

  // Next output values; write address/data only move when the current write completes
  always_comb begin
    w_wr_en_nxt = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_code_nxt  = r_code;
    w_busy_nxt  = (w_state_nxt != S_HUNT);
    if (w_tmo_exp) begin
      w_err_nxt  = 1'b1;
      w_code_nxt = ERR_TMO;
    end
    unique case (r_state)
      S_GET_LEN: begin
        if (w_rx_valid && w_len_bad) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = ERR_LEN;
        end
      end
      S_GET_CHK: begin
        if (w_rx_valid) begin
          if (w_chk_ok) begin
            w_wr_en_nxt = 1'b1;
            w_addr_nxt  = r_base;
            w_data_nxt  = r_buf[0];
          end else begin
            w_err_nxt  = 1'b1;
            w_code_nxt = ERR_CHK;
          end
        end
      end
      S_COMMIT: begin
        if (w_rx_valid) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = ERR_OVERRUN;
        end
        if (w_wr_fire) begin
          if (w_idx_last) begin
            w_done_nxt = 1'b1;
          end else begin
            w_wr_en_nxt = 1'b1;
            w_addr_nxt  = r_base + w_idx_inc;
            w_data_nxt  = r_buf[IDX_W'(w_idx_inc)];
          end
        end else begin
          w_wr_en_nxt = r_wr_en;
        end
      end
      default: ;
    endcase
  end

  // Frame datapath: base, length, index, running XOR and inter-byte timer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_base <= 8'h00;
      r_len  <= 8'h00;
      r_idx  <= 8'h00;
      r_xor  <= 8'h00;
      r_tmo  <= '0;
    end else begin
      if (w_in_frame) begin
        if (w_rx_valid) r_tmo <= '0;
        else            r_tmo <= r_tmo + TMO_W'(1);
      end else begin
        r_tmo <= '0;
      end
      unique case (r_state)
        S_HUNT: begin
          r_xor <= 8'h00;
          r_idx <= 8'h00;
        end
        S_GET_ADDR: begin
          if (w_rx_valid) begin
            r_base <= w_rx_data;
            r_xor  <= r_xor ^ w_rx_data;
          end
        end
        S_GET_LEN: begin
          if (w_rx_valid && !w_len_bad) begin
            r_len <= w_rx_data;
            r_idx <= 8'h00;
            r_xor <= r_xor ^ w_rx_data;
          end
        end
        S_GET_DATA: begin
          if (w_rx_valid) begin
            r_idx <= w_idx_inc;
            r_xor <= r_xor ^ w_rx_data;
          end
        end
        S_GET_CHK: begin
          if (w_rx_valid) r_idx <= 8'h00;
        end
        S_COMMIT: begin
          if (w_wr_fire) r_idx <= w_idx_inc;
        end
        default: ;
      endcase
    end
  end

  // Payload buffer; contents are don't-care out of reset
  always_ff @(posedge clk) begin
    if ((r_state == S_GET_DATA) && w_rx_valid) r_buf[IDX_W'(r_idx)] <= w_rx_data;
  end

endmodule
